// File: rtl/lane_stage_pkg.sv
// Shared definitions for the lane skid stage: mode encodings, skid FSM states,
// and a width-generic saturating increment.
package lane_stage_pkg;

    localparam int unsigned MODE_PASS = 0;
    localparam int unsigned MODE_REG  = 1;
    localparam int unsigned MODE_SKID = 2;

    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} skid_state_e;

    localparam int unsigned SAT_MAX_W = 64;

    // Increments value, holding at the all-ones value of a 'width'-bit counter.
    function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] value,
                                                     input int unsigned          width);
        logic [SAT_MAX_W-1:0] max_v;
        if (width >= SAT_MAX_W) max_v = '1;
        else                    max_v = (64'd1 << width) - 64'd1;
        return (value >= max_v) ? max_v : value + 64'd1;
    endfunction

endpackage

// File: rtl/lane_sat_counter.sv
// Saturating event counter with synchronous clear that takes priority over increment.
module lane_sat_counter
    import lane_stage_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr)      count_d = '0;
        else if (inc) count_d = CNT_W'(sat_inc(SAT_MAX_W'(count_q), CNT_W));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/lane_skid_stage.sv
// Elastic valid/ready stage for a LANES-wide bundle; MODE selects passthrough,
// single pipeline register, or 2-entry skid buffer. Includes handshake/stall counters.
module lane_skid_stage
    import lane_stage_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LANES = 5,
    parameter int unsigned MODE  = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic [CNT_W-1:0]       xfer_cnt,
    output logic [CNT_W-1:0]       stall_cnt,
    input  logic                   clr_cnt
);

    logic out_xfer;
    logic out_stall;

    assign out_xfer  = out_valid & out_ready;
    assign out_stall = out_valid & ~out_ready;

    lane_sat_counter #(.CNT_W(CNT_W)) u_xfer_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_cnt),
        .inc   (out_xfer),
        .count (xfer_cnt)
    );

    lane_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_cnt),
        .inc   (out_stall),
        .count (stall_cnt)
    );

    generate
        case (MODE)
            MODE_PASS: begin : g_pass
                assign out_valid = in_valid;
                assign in_ready  = out_ready;
                assign out_data  = in_data;
            end

            MODE_REG: begin : g_reg
                logic valid_q;
                logic valid_d;
                logic load;

                assign in_ready = ~valid_q | out_ready;

                always_comb begin
                    load    = in_valid & in_ready;
                    valid_d = valid_q;
                    if (load)           valid_d = 1'b1;
                    else if (out_ready) valid_d = 1'b0;
                end

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) valid_q <= 1'b0;
                    else        valid_q <= valid_d;
                end

                assign out_valid = valid_q;

                for (genvar i = 0; i < LANES; i++) begin : g_lane
                    logic [WIDTH-1:0] data_q;
                    logic [WIDTH-1:0] data_d;

                    always_comb begin
                        data_d = data_q;
                        if (load) data_d = in_data[i*WIDTH +: WIDTH];
                    end

                    always_ff @(posedge clk or negedge rst_n) begin
                        if (!rst_n) data_q <= '0;
                        else        data_q <= data_d;
                    end

                    assign out_data[i*WIDTH +: WIDTH] = data_q;
                end
            end

            MODE_SKID: begin : g_skid
                skid_state_e state_q;
                skid_state_e state_d;
                logic        in_ready_q;
                logic        in_ready_d;
                logic        in_xfer;
                logic        load_m_in;
                logic        load_m_s;
                logic        load_s;

                // M valid = state != EMPTY, S valid = state == FULL
                always_comb begin
                    state_d   = state_q;
                    load_m_in = 1'b0;
                    load_m_s  = 1'b0;
                    load_s    = 1'b0;
                    in_xfer   = in_valid & in_ready_q;
                    case (state_q)
                        ST_EMPTY: begin
                            if (in_xfer) begin
                                load_m_in = 1'b1;
                                state_d   = ST_ONE;
                            end
                        end
                        ST_ONE: begin
                            case ({in_xfer, out_ready})
                                2'b10: begin
                                    load_s  = 1'b1;
                                    state_d = ST_FULL;
                                end
                                2'b01:   state_d   = ST_EMPTY;
                                2'b11:   load_m_in = 1'b1;
                                default: state_d   = ST_ONE;
                            endcase
                        end
                        ST_FULL: begin
                            if (out_ready) begin
                                load_m_s = 1'b1;
                                state_d  = ST_ONE;
                            end
                        end
                        default: state_d = ST_EMPTY;
                    endcase
                    in_ready_d = (state_d != ST_FULL);
                end

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        state_q    <= ST_EMPTY;
                        in_ready_q <= 1'b1;
                    end else begin
                        state_q    <= state_d;
                        in_ready_q <= in_ready_d;
                    end
                end

                assign in_ready  = in_ready_q;
                assign out_valid = (state_q != ST_EMPTY);

                for (genvar i = 0; i < LANES; i++) begin : g_lane
                    logic [WIDTH-1:0] m_q;
                    logic [WIDTH-1:0] m_d;
                    logic [WIDTH-1:0] s_q;
                    logic [WIDTH-1:0] s_d;

                    always_comb begin
                        m_d = m_q;
                        s_d = s_q;
                        if (load_m_in)     m_d = in_data[i*WIDTH +: WIDTH];
                        else if (load_m_s) m_d = s_q;
                        if (load_s)        s_d = in_data[i*WIDTH +: WIDTH];
                    end

                    always_ff @(posedge clk or negedge rst_n) begin
                        if (!rst_n) begin
                            m_q <= '0;
                            s_q <= '0;
                        end else begin
                            m_q <= m_d;
                            s_q <= s_d;
                        end
                    end

                    assign out_data[i*WIDTH +: WIDTH] = m_q;
                end
            end

            default: begin : g_bad_mode
                $error("lane_skid_stage: unsupported MODE %0d", MODE);
            end
        endcase
    endgenerate

endmodule

// File: doc/lane_skid_stage.md
Name: lane_skid_stage

Overview:
- Elastic valid/ready stage placed directly downstream of the generate-structured lane producers.
- Registers a LANES-wide data bundle (one WIDTH slice per lane) toward the consumer.
- Implementation style is chosen at elaboration by MODE: passthrough, single pipeline register, or 2-entry skid buffer.
- Provides saturating transfer and stall counters for observability.

Parameters:
- WIDTH, 8: bits per lane.
- LANES, 5: number of lanes; per-lane storage is built with a for-generate.
- MODE, 2: 0 = passthrough, 1 = pipeline register, 2 = skid buffer. Any other value is an elaboration error via $error in a generate-case default branch.
- CNT_W, 16: width of each statistics counter.

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  upstream data valid.
- in_ready  output  1  stage can accept.
- in_data  input  LANES*WIDTH  lane i occupies bits [i*WIDTH +: WIDTH].
- out_valid  output  1  downstream data valid.
- out_ready  input  1  downstream accepts.
- out_data  output  LANES*WIDTH  same lane packing as in_data.
- xfer_cnt  output  CNT_W  count of output handshakes, saturating.
- stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0, saturating.
- clr_cnt  input  1  synchronous clear of both counters.

Behaviour:
- Handshake definitions: input transfer = in_valid & in_ready; output transfer = out_valid & out_ready.
- Handshake rules: once out_valid is high, out_valid and out_data are held stable until an output transfer. in_ready never depends combinationally on in_valid.
- Reset values (asynchronous, while rst_n=0): out_valid=0, all data registers 0, xfer_cnt=0, stall_cnt=0. in_ready=1 in MODE 1/2; in MODE 0, in_ready follows out_ready.
- Reset deasserted mid-burst: no data survives; the first accepted beat after reset is the first output beat.
- MODE 0: out_valid=in_valid, in_ready=out_ready, out_data=in_data. Zero latency. Counters still operate.
- MODE 1:
  - in_ready = ~out_valid | out_ready (combinational path from out_ready).
  - An input transfer loads the register. out_valid is set the next cycle. Latency 1.
  - Output transfer with no simultaneous input transfer clears out_valid.
  - Simultaneous input and output transfer: register reloads and out_valid stays 1. Full throughput, no bubble.
- MODE 2:
  - Main register M and skid register S, each with its own valid flag; LANES*WIDTH bits each.
  - in_ready is a flop, equal to ~S_valid. No combinational ready path.
  - States: EMPTY (M,S invalid), ONE (M valid), FULL (M,S valid).
  - EMPTY: input transfer loads M, next state ONE.
  - ONE, input only: load S, go to FULL, in_ready drops the next cycle.
  - ONE, output only: go to EMPTY.
  - ONE, both: load M, stay in ONE.
  - FULL: no input accepted. Output transfer moves S to M, go to ONE, in_ready rises the next cycle.
  - out_valid = M_valid. Latency 1. Sustained throughput 1 beat/cycle. Order preserved; no beat dropped or duplicated.
- Counters:
  - xfer_cnt increments on each output transfer and stalls at 2^CNT_W-1 (no wrap).
  - stall_cnt increments when out_valid & ~out_ready, also saturating.
  - clr_cnt has priority over increment in the same cycle; the counter becomes 0.
- All lanes are identical; no lane-dependent behaviour.

Decomposition:
- Package lane_stage_pkg holds:
  - mode encoding localparams MODE_PASS=0, MODE_REG=1, MODE_SKID=2;
  - typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} skid_state_e;
  - a saturating-increment function parameterised by width.
- One sub-module: lane_sat_counter (CNT_W, clk, rst_n, clr, inc, count), instantiated twice.
- Lane storage stays inline using labelled generate blocks.

Test Plan:
- Reset mid-burst, MODE 2: 3 beats accepted, assert rst_n=0 for 1 cycle -> immediately out_valid=0, counters 0, in_ready=1 after release; next beat 0x11 (all lanes) emerges first.
- MODE 2 backpressure: send 0x01,0x02,0x03 back-to-back with out_ready=0 -> in_ready drops after 2 accepted; raise out_ready -> output 0x01,0x02,0x03 in order, stall_cnt equals the cycles held low.
- MODE 1 full throughput: 100 consecutive beats with out_ready=1 -> 100 outputs on consecutive cycles at latency 1, xfer_cnt=100.
- Lane packing, LANES=5, WIDTH=8: in_data lane i = i+0xA0 -> out_data lane i = i+0xA0, bit-exact.
- Saturation, CNT_W=4: 20 output transfers -> xfer_cnt holds at 15; clr_cnt pulsed together with a transfer -> 0.
- MODE 0: toggle out_ready randomly -> in_ready equals out_ready every cycle, out_data equals in_data with zero latency.
